// File: rtl/cache_pkg.sv
// Shared cache-side definitions: default index geometry and the flush-sweep state encoding.
package cache_pkg;

  localparam int DEF_IDX_W = 7;
  localparam int DEF_LINES = 2 ** DEF_IDX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/line_sel_valid_if.sv
// Controller <-> line-select/valid-array bundle; the controller is master, line_sel_valid is slave.
interface line_sel_valid_if
  import cache_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W
);
  localparam int LINES = 2 ** IDX_W;

  logic             en;
  logic [IDX_W-1:0] idx;
  logic             fill;
  logic             inval;
  logic             flush_req;
  logic [LINES-1:0] sel_onehot;
  logic             sel_vld;
  logic             hit;
  logic             busy;
  logic             flush_done;
  logic [LINES-1:0] valid_vec;

  modport master (
    output en, idx, fill, inval, flush_req,
    input  sel_onehot, sel_vld, hit, busy, flush_done, valid_vec
  );

  modport slave (
    input  en, idx, fill, inval, flush_req,
    output sel_onehot, sel_vld, hit, busy, flush_done, valid_vec
  );

endinterface

// File: rtl/onehot_dec.sv
// Combinational IDX_W -> 2**IDX_W one-hot decoder with enable; output is all zero when en=0.
module onehot_dec #(
  parameter int IDX_W = 7
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [2**IDX_W-1:0] onehot
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    onehot      = '0;
    onehot[idx] = en;
  end

endmodule

// File: rtl/line_sel_valid.sv
// Registered line select plus per-line valid array with fill/inval and a chunked flush sweep.
// Optional LINE_SEL_ONEHOT_CHK_EN adds a sticky sel_err output checking sel_onehot integrity.
module line_sel_valid
  import cache_pkg::*;
#(
  parameter int IDX_W         = DEF_IDX_W,
  parameter int FLUSH_PER_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  line_sel_valid_if.slave  bus
`ifdef LINE_SEL_ONEHOT_CHK_EN
  ,
  output logic             sel_err
`endif
);

  localparam int LINES  = 2 ** IDX_W;
  localparam int NCHUNK = LINES / FLUSH_PER_CYC;
  localparam int FPTR_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [FPTR_W-1:0] FPTR_LAST = FPTR_W'(NCHUNK - 1);

  flush_state_t      state_q, state_d;
  logic [FPTR_W-1:0] fptr_q, fptr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  idx_oh;
  logic [LINES-1:0]  chunk_mask;
  logic [LINES-1:0]  sel_onehot_q;
  logic              sel_vld_q, hit_q, done_q;
  logic              lookup, done_d;

  // One decode serves both the lookup select and the fill/inval write enable.
  onehot_dec #(.IDX_W(IDX_W)) u_dec (
    .en     (state_q == IDLE),
    .idx    (bus.idx),
    .onehot (idx_oh)
  );

  always_comb begin
    chunk_mask = '0;
    for (int i = 0; i < LINES; i++) begin
      if ((i / FLUSH_PER_CYC) == int'(fptr_q)) chunk_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    fptr_d  = fptr_q;
    valid_d = valid_q;
    lookup  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush request swallows any same-cycle lookup or write.
        if (bus.flush_req) begin
          state_d = FLUSH;
          fptr_d  = '0;
        end else begin
          lookup = bus.en;
          if (bus.inval)     valid_d = valid_q & ~idx_oh;
          else if (bus.fill) valid_d = valid_q | idx_oh;
        end
      end
      FLUSH: begin
        valid_d = valid_q & ~chunk_mask;
        fptr_d  = fptr_q + FPTR_W'(1);
        if (fptr_q == FPTR_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the valid array is a flop vector, not RAM, so it is reset with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fptr_q       <= '0;
      valid_q      <= '0;
      sel_onehot_q <= '0;
      sel_vld_q    <= 1'b0;
      hit_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      fptr_q       <= fptr_d;
      valid_q      <= valid_d;
      sel_onehot_q <= lookup ? idx_oh : '0;
      sel_vld_q    <= lookup;
      hit_q        <= lookup && |(valid_q & idx_oh);
      done_q       <= done_d;
    end
  end

  assign bus.sel_onehot = sel_onehot_q;
  assign bus.sel_vld    = sel_vld_q;
  assign bus.hit        = hit_q;
  assign bus.busy       = (state_q == FLUSH);
  assign bus.flush_done = done_q;
  assign bus.valid_vec  = valid_q;

`ifdef LINE_SEL_ONEHOT_CHK_EN
  logic sel_bad;
  assign sel_bad = ((sel_onehot_q & (sel_onehot_q - LINES'(1))) != '0) ||
                   (!sel_vld_q && (sel_onehot_q != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= sel_err | sel_bad;
  end
`endif

endmodule
